// File: rtl/student_serial_adder.sv
// Multi-cycle serial adder: {carry,sum} = a + b + cin, BITS_PER_CYCLE bits per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVERFLOW_EN.
module student_serial_adder #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_check
            $error("student_serial_adder: BITS_PER_CYCLE must evenly divide WIDTH");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t                            state, state_next;
    logic [WIDTH-1:0]                  a_sr, b_sr, psum;
    logic                              cr;
    logic [CW-1:0]                     count;
    logic                              accept, last_step;
    logic [BITS_PER_CYCLE-1:0]         chain_sum;
    logic [BITS_PER_CYCLE:0]           chain_c;
    logic [WIDTH+BITS_PER_CYCLE-1:0]   psum_cat;
    logic [WIDTH-1:0]                  psum_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_step  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == CW'(STEPS - 1)) begin
                    last_step  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Ripple of full-adder cells over the low slice of the operand shift registers.
    always_comb begin
        chain_c    = '0;
        chain_sum  = '0;
        chain_c[0] = cr;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            chain_sum[i]   = a_sr[i] ^ b_sr[i] ^ chain_c[i];
            chain_c[i+1]   = (a_sr[i] & b_sr[i]) | (chain_c[i] & (a_sr[i] ^ b_sr[i]));
        end
    end

    assign psum_cat  = {chain_sum, psum};
    assign psum_next = psum_cat[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];

    // Outputs only move at the final step, so the previous result is held through RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            psum     <= '0;
            cr       <= 1'b0;
            count    <= '0;
            done     <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            overflow <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_sr  <= a;
                b_sr  <= b;
                cr    <= cin;
                psum  <= '0;
                count <= '0;
            end else if (state == RUN) begin
                a_sr  <= a_sr >> BITS_PER_CYCLE;
                b_sr  <= b_sr >> BITS_PER_CYCLE;
                cr    <= chain_c[BITS_PER_CYCLE];
                psum  <= psum_next;
                count <= count + CW'(1);
                if (last_step) begin
                    sum      <= psum_next;
                    carry    <= chain_c[BITS_PER_CYCLE];
                    done     <= 1'b1;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                    overflow <= chain_c[BITS_PER_CYCLE] ^ chain_c[BITS_PER_CYCLE-1];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_student_serial_adder.sv
// Self-checking bench for student_serial_adder: 8-bit/1-bit-per-cycle and 16-bit/4-bit-per-cycle instances.
// Results are predicted into a scoreboard queue and checked by a monitor on each done pulse.
module tb_student_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = '0, b = '0;
    logic        cin = 1'b0;
    logic        busy, done, carry;
    logic [7:0]  sum;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        cin16 = 1'b0;
    logic        busy16, done16, carry16;
    logic [15:0] sum16;

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic        overflow, overflow16;
`endif

    int          vec_count  = 0;
    int          miss_count = 0;

    logic [9:0]  sb_q[$];
    logic [9:0]  mon_exp;
    logic [7:0]  held_sum   = '0;
    logic        held_carry = 1'b0;
    logic        held_ovf   = 1'b0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       c;
        logic       v;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    student_serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .carry(carry)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        , .overflow(overflow)
`endif
    );

    student_serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .carry(carry16)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        , .overflow(overflow16)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops on every done pulse, otherwise checks the result is held.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    checkOutput("done_unexpected", {31'd0, done}, 32'd0);
                end else begin
                    mon_exp = sb_q.pop_front();
                    checkOutput("sum", {24'd0, sum}, {24'd0, mon_exp[7:0]});
                    checkOutput("carry", {31'd0, carry}, {31'd0, mon_exp[8]});
`ifdef SERIAL_ADDER_OVERFLOW_EN
                    checkOutput("overflow", {31'd0, overflow}, {31'd0, mon_exp[9]});
`endif
                    held_sum   = mon_exp[7:0];
                    held_carry = mon_exp[8];
                    held_ovf   = mon_exp[9];
                end
            end else begin
                checkOutput("hold_sum", {24'd0, sum}, {24'd0, held_sum});
                checkOutput("hold_carry", {31'd0, carry}, {31'd0, held_carry});
`ifdef SERIAL_ADDER_OVERFLOW_EN
                checkOutput("hold_overflow", {31'd0, overflow}, {31'd0, held_ovf});
`endif
            end
        end
    end

    // Called at posedge+1; start is sampled at the following edge.
    task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                                 input logic [7:0] es, input logic ec, input logic ev);
        a     = ta;
        b     = tb_v;
        cin   = tc;
        start = 1'b1;
        sb_q.push_back({ev, ec, es});
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        cin   = 1'(($urandom));
        checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic waitDone(input int steps, input string tag);
        int cyc;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 20);
        checkOutput({tag, "_latency"}, cyc, steps);
        checkOutput({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run16(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                         input logic [15:0] es, input logic ec);
        int cyc;
        a16     = ta;
        b16     = tb_v;
        cin16   = tc;
        start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done16 && cyc < 20);
        checkOutput("w16_latency", cyc, 32'd4);
        checkOutput("w16_sum", {16'd0, sum16}, {16'd0, es});
        checkOutput("w16_carry", {31'd0, carry16}, {31'd0, ec});
        @(posedge clk);
        #1;
        checkOutput("w16_done_pulse", {31'd0, done16}, 32'd0);
    endtask

    initial begin
        int seen;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

        #1;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_sum", {24'd0, sum}, 32'd0);
        checkOutput("reset_carry", {31'd0, carry}, 32'd0);
        checkOutput("reset_sum16", {16'd0, sum16}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_sum", {24'd0, sum}, 32'd0);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, vecs[i].v);
            waitDone(8, "table");
            @(posedge clk);
            #1;
        end

        // start while busy must be ignored
        applyStimulus(8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        a = 8'h01;
        b = 8'h01;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(5, "busy_start");
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) seen = 1;
        end
        checkOutput("busy_start_single_done", seen, 32'd0);

        // back-to-back: second start issued during the done cycle
        applyStimulus(8'h55, 8'h0A, 1'b0, 8'h5F, 1'b0, 1'b0);
        waitDone(8, "b2b_first");
        applyStimulus(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        waitDone(8, "b2b_second");
        @(posedge clk);
        #1;

        // asynchronous abort in the middle of RUN
        applyStimulus(8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        held_sum   = '0;
        held_carry = 1'b0;
        held_ovf   = 1'b0;
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_sum", {24'd0, sum}, 32'd0);
        checkOutput("abort_carry", {31'd0, carry}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1;
        end
        checkOutput("abort_no_done", seen, 32'd0);

        applyStimulus(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
        waitDone(8, "after_abort");
        @(posedge clk);
        #1;

        run16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run16(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
        run16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

        checkOutput("scoreboard_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
